// File: rtl/payment_collector_pkg.sv
// Shared types and constants for the payment collector: state encoding,
// accepted denominations and the legal price range.
package payment_collector_pkg;

  typedef enum logic [2:0] {
    StIdle         = 3'd0,
    StCollect      = 3'd1,
    StIssue        = 3'd2,
    StWaitDispense = 3'd3
  } pc_state_e;

  // Denominations in euros, sized for the 6-bit running total.
  localparam logic [5:0] Coin2Value  = 6'd2;
  localparam logic [5:0] Note10Value = 6'd10;
  localparam logic [5:0] Note20Value = 6'd20;

  localparam logic [4:0] MinPrice = 5'd2;
  localparam logic [4:0] MaxPrice = 5'd28;

  // Only even prices inside the legal range can be settled with the denominations on offer.
  function automatic logic price_is_valid(input logic [4:0] p);
    return (p[0] == 1'b0) && (p >= MinPrice) && (p <= MaxPrice);
  endfunction

endpackage

// File: rtl/payment_collector_dispense_watchdog.sv
// Counts cycles spent waiting on the dispenser and flags the last allowed cycle.
module payment_collector_dispense_watchdog #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_count;

  // Counter restarts whenever the wait state is left, so each wait gets a full budget.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_count <= '0;
    end else if (!o_expired) begin
      r_count <= r_count + CntW'(1);
    end
  end

  // High during the TIMEOUT-th consecutive wait cycle.
  assign o_expired = i_run && (r_count == LastCount);

endmodule

// File: rtl/payment_collector.sv
// Vending payment controller: accepts a price, collects coins/notes, issues
// change or a refund to the dispenser and reports the outcome as one-cycle pulses.
module payment_collector
  import payment_collector_pkg::*;
#(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       priceValid,
  input  logic [4:0] price,
  input  logic       coin2In,
  input  logic       note10In,
  input  logic       note20In,
  input  logic       cancel,
  input  logic       noMoneyLeft,
  output logic [4:0] moneyToGive,
  output logic       saleDone,
  output logic       refundDone,
  output logic       priceError,
  output logic       insertReject,
  output logic       dispenseFault,
  output logic [5:0] paid,
  output logic       busy,
  output logic [2:0] state
);

  pc_state_e  r_state, w_state_next;
  logic [4:0] r_price, w_price_next;
  logic [5:0] r_paid, w_paid_next;
  logic [4:0] r_money, w_money_next;
  logic       r_refund, w_refund_next;
  logic       r_sale_done, w_sale_done;
  logic       r_refund_done, w_refund_done;
  logic       r_price_error, w_price_error;
  logic       r_insert_reject, w_insert_reject;
  logic       r_dispense_fault, w_dispense_fault;

  logic       w_any_ins;
  logic       w_multi_ins;
  logic [5:0] w_denom;
  logic [5:0] w_sum;
  logic [4:0] w_change;
  logic       w_expired;

  payment_collector_dispense_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_run    (r_state == StWaitDispense),
    .o_expired(w_expired)
  );

  assign w_any_ins   = coin2In | note10In | note20In;
  assign w_multi_ins = (coin2In & note10In) | (coin2In & note20In) | (note10In & note20In);

  // Pick the single counted denomination: note20 over note10 over coin2.
  always_comb begin
    w_denom = '0;
    if (note20In) begin
      w_denom = Note20Value;
    end else if (note10In) begin
      w_denom = Note10Value;
    end else if (coin2In) begin
      w_denom = Coin2Value;
    end
  end

  assign w_sum    = r_paid + w_denom;
  // The true difference never exceeds 26, so the 5-bit wrap-around result is exact.
  assign w_change = w_sum[4:0] - r_price;

  // Next-state, datapath and pulse decisions for the transaction FSM.
  always_comb begin
    w_state_next     = r_state;
    w_price_next     = r_price;
    w_paid_next      = r_paid;
    w_refund_next    = r_refund;
    w_money_next     = '0;
    w_sale_done      = 1'b0;
    w_refund_done    = 1'b0;
    w_price_error    = 1'b0;
    w_insert_reject  = 1'b0;
    w_dispense_fault = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_insert_reject = w_any_ins;
        if (priceValid) begin
          if (price_is_valid(price)) begin
            w_state_next = StCollect;
            w_price_next = price;
            w_paid_next  = '0;
          end else begin
            w_price_error = 1'b1;
          end
        end
      end

      StCollect: begin
        if (cancel) begin
          w_insert_reject = w_any_ins;
          if (r_paid == 6'd0) begin
            w_refund_done = 1'b1;
            w_state_next  = StIdle;
          end else begin
            w_money_next  = r_paid[4:0];
            w_refund_next = 1'b1;
            w_state_next  = StIssue;
          end
        end else if (w_any_ins) begin
          w_insert_reject = w_multi_ins;
          if (w_sum >= {1'b0, r_price}) begin
            if (w_change == 5'd0) begin
              w_sale_done  = 1'b1;
              w_paid_next  = '0;
              w_state_next = StIdle;
            end else begin
              w_money_next  = w_change;
              w_refund_next = 1'b0;
              w_paid_next   = w_sum;
              w_state_next  = StIssue;
            end
          end else begin
            w_paid_next = w_sum;
          end
        end
      end

      StIssue: begin
        w_insert_reject = w_any_ins;
        w_state_next    = StWaitDispense;
      end

      StWaitDispense: begin
        w_insert_reject = w_any_ins;
        // A completion arriving on the last allowed cycle still counts as success.
        if (noMoneyLeft) begin
          w_sale_done   = !r_refund;
          w_refund_done = r_refund;
          w_paid_next   = '0;
          w_state_next  = StIdle;
        end else if (w_expired) begin
          w_dispense_fault = 1'b1;
          w_paid_next      = '0;
          w_state_next     = StIdle;
        end
      end

      default: begin
        w_state_next = StIdle;
        w_paid_next  = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops any transaction in flight silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= StIdle;
      r_price          <= '0;
      r_paid           <= '0;
      r_money          <= '0;
      r_refund         <= 1'b0;
      r_sale_done      <= 1'b0;
      r_refund_done    <= 1'b0;
      r_price_error    <= 1'b0;
      r_insert_reject  <= 1'b0;
      r_dispense_fault <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_price          <= w_price_next;
      r_paid           <= w_paid_next;
      r_money          <= w_money_next;
      r_refund         <= w_refund_next;
      r_sale_done      <= w_sale_done;
      r_refund_done    <= w_refund_done;
      r_price_error    <= w_price_error;
      r_insert_reject  <= w_insert_reject;
      r_dispense_fault <= w_dispense_fault;
    end
  end

  assign moneyToGive   = r_money;
  assign saleDone      = r_sale_done;
  assign refundDone    = r_refund_done;
  assign priceError    = r_price_error;
  assign insertReject  = r_insert_reject;
  assign dispenseFault = r_dispense_fault;
  assign paid          = r_paid;
  assign busy          = (r_state != StIdle);
  assign state         = r_state;

endmodule

// File: tb/tb_payment_collector.sv
// Self-checking bench for payment_collector: scripted vector table, hand-written
// corner sequences and random transactions scored against a transaction-level model.
module tb_payment_collector;
  import payment_collector_pkg::*;

  localparam int TbTimeout = 40;
  localparam int NumVecs   = 27;
  localparam int NumRandom = 60;

  localparam int SI = int'(StIdle);
  localparam int SC = int'(StCollect);
  localparam int SS = int'(StIssue);
  localparam int SW = int'(StWaitDispense);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       priceValid = 1'b0;
  logic [4:0] price = 5'd0;
  logic       coin2In = 1'b0;
  logic       note10In = 1'b0;
  logic       note20In = 1'b0;
  logic       cancel = 1'b0;
  logic       noMoneyLeft = 1'b0;
  logic [4:0] moneyToGive;
  logic       saleDone, refundDone, priceError, insertReject, dispenseFault;
  logic [5:0] paid;
  logic       busy;
  logic [2:0] state;

  payment_collector #(.TIMEOUT(TbTimeout)) dut (
    .clock        (clock),
    .reset        (reset),
    .priceValid   (priceValid),
    .price        (price),
    .coin2In      (coin2In),
    .note10In     (note10In),
    .note20In     (note20In),
    .cancel       (cancel),
    .noMoneyLeft  (noMoneyLeft),
    .moneyToGive  (moneyToGive),
    .saleDone     (saleDone),
    .refundDone   (refundDone),
    .priceError   (priceError),
    .insertReject (insertReject),
    .dispenseFault(dispenseFault),
    .paid         (paid),
    .busy         (busy),
    .state        (state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Inputs per cycle and the outputs expected after the following rising edge.
  // pd = -1 leaves paid unchecked.
  typedef struct {
    int pv; int pr; int c2; int n10; int n20; int cn; int nml;
    int st; int pd; int mtg; int sd; int rd; int pe; int ir; int df;
  } vec_t;

  vec_t vecs[NumVecs];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int pv, input int pr, input int c2, input int n10, input int n20,
                       input int cn, input int nml);
    priceValid  = (pv != 0);
    price       = 5'(pr);
    coin2In     = (c2 != 0);
    note10In    = (n10 != 0);
    note20In    = (n20 != 0);
    cancel      = (cn != 0);
    noMoneyLeft = (nml != 0);
  endtask

  task automatic idle_inputs();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all(input string tag, input int st, input int pd, input int mtg,
                           input int sd, input int rd, input int pe, input int ir, input int df);
    check({tag, "/state"}, int'(state), st);
    if (pd >= 0) check({tag, "/paid"}, int'(paid), pd);
    check({tag, "/moneyToGive"}, int'(moneyToGive), mtg);
    check({tag, "/saleDone"}, int'(saleDone), sd);
    check({tag, "/refundDone"}, int'(refundDone), rd);
    check({tag, "/priceError"}, int'(priceError), pe);
    check({tag, "/insertReject"}, int'(insertReject), ir);
    check({tag, "/dispenseFault"}, int'(dispenseFault), df);
    check({tag, "/busy"}, int'(busy), (st != SI) ? 1 : 0);
  endtask

  function automatic int model_price_ok(input int p);
    return ((p % 2) == 0 && p >= 2 && p <= 28) ? 1 : 0;
  endfunction

  // One random customer transaction, scored against the pricing rules.
  task automatic random_txn(input int t);
    int p, paid_m, amount, refund, done, iter, r, k, n, d, delay;
    int c2, n10, n20, cn;
    string tag;
    tag = $sformatf("rnd%0d", t);
    if ($urandom_range(0, 4) == 0) p = int'($urandom_range(0, 31));
    else p = 2 * int'($urandom_range(1, 14));
    drive(1, p, 0, 0, 0, 0, 0);
    tick();
    idle_inputs();
    if (model_price_ok(p) == 0) begin
      check({tag, "/priceError"}, int'(priceError), 1);
      check({tag, "/state_after_bad_price"}, int'(state), SI);
      return;
    end
    check({tag, "/state_collect"}, int'(state), SC);
    paid_m = 0; amount = 0; refund = 0; done = 0; iter = 0;
    while (done == 0) begin
      iter++;
      c2 = 0; n10 = 0; n20 = 0; cn = 0;
      r = int'($urandom_range(0, 99));
      if (iter > 40 || r < 8) begin
        cn = 1;
        k = int'($urandom_range(0, 3));
        c2 = (k == 1) ? 1 : 0; n10 = (k == 2) ? 1 : 0; n20 = (k == 3) ? 1 : 0;
      end else if (r < 20) begin
        // nothing inserted this cycle
      end else if (r < 32) begin
        c2 = int'($urandom_range(0, 1)); n10 = int'($urandom_range(0, 1));
        n20 = int'($urandom_range(0, 1));
      end else begin
        k = int'($urandom_range(0, 2));
        c2 = (k == 0) ? 1 : 0; n10 = (k == 1) ? 1 : 0; n20 = (k == 2) ? 1 : 0;
      end
      drive(0, 0, c2, n10, n20, cn, 0);
      tick();
      idle_inputs();
      n = c2 + n10 + n20;
      if (cn != 0) begin
        check({tag, "/reject_on_cancel"}, int'(insertReject), (n > 0) ? 1 : 0);
        amount = paid_m; refund = 1; done = 1;
      end else begin
        check({tag, "/reject"}, int'(insertReject), (n > 1) ? 1 : 0);
        if (n > 0) begin
          d = (n20 != 0) ? 20 : ((n10 != 0) ? 10 : 2);
          if (paid_m + d >= p) begin
            amount = paid_m + d - p; refund = 0; done = 1;
          end
          paid_m += d;
        end
      end
      if (done == 0) begin
        check({tag, "/state_collect"}, int'(state), SC);
        check({tag, "/paid"}, int'(paid), paid_m);
      end
    end
    if (amount == 0) begin
      check({tag, "/state_direct_idle"}, int'(state), SI);
      check({tag, "/saleDone_direct"}, int'(saleDone), (refund == 0) ? 1 : 0);
      check({tag, "/refundDone_direct"}, int'(refundDone), refund);
      check({tag, "/money_zero"}, int'(moneyToGive), 0);
      check({tag, "/paid_cleared"}, int'(paid), 0);
    end else begin
      check({tag, "/state_issue"}, int'(state), SS);
      check({tag, "/money"}, int'(moneyToGive), amount);
      tick();
      check({tag, "/state_wait"}, int'(state), SW);
      check({tag, "/money_released"}, int'(moneyToGive), 0);
      delay = int'($urandom_range(0, 6));
      for (int i = 0; i < delay; i++) tick();
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      idle_inputs();
      check({tag, "/state_done"}, int'(state), SI);
      check({tag, "/saleDone"}, int'(saleDone), (refund == 0) ? 1 : 0);
      check({tag, "/refundDone"}, int'(refundDone), refund);
      check({tag, "/paid_cleared"}, int'(paid), 0);
      check({tag, "/busy"}, int'(busy), 0);
    end
  endtask

  initial begin
    int n;
    //         pv  pr c2 n10 n20 cn nml  st  pd mtg sd rd pe ir df
    vecs[0]  = '{1,  7, 0, 0, 0, 0, 0,  SI,  0,  0, 0, 0, 1, 0, 0};
    vecs[1]  = '{1, 30, 0, 0, 0, 0, 0,  SI,  0,  0, 0, 0, 1, 0, 0};
    vecs[2]  = '{0,  0, 1, 0, 0, 0, 1,  SI,  0,  0, 0, 0, 0, 1, 0};
    vecs[3]  = '{1, 16, 0, 0, 0, 0, 0,  SC,  0,  0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1,  4, 0, 1, 0, 0, 0,  SC, 10,  0, 0, 0, 0, 0, 0};
    vecs[5]  = '{0,  0, 0, 1, 0, 0, 0,  SS, -1,  4, 0, 0, 0, 0, 0};
    vecs[6]  = '{0,  0, 0, 0, 0, 0, 0,  SW, -1,  0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0,  0, 1, 0, 0, 1, 0,  SW, -1,  0, 0, 0, 0, 1, 0};
    vecs[8]  = '{0,  0, 0, 0, 0, 0, 1,  SI,  0,  0, 1, 0, 0, 0, 0};
    vecs[9]  = '{1,  6, 0, 0, 0, 0, 0,  SC,  0,  0, 0, 0, 0, 0, 0};
    vecs[10] = '{0,  0, 1, 0, 0, 0, 0,  SC,  2,  0, 0, 0, 0, 0, 0};
    vecs[11] = '{0,  0, 1, 0, 0, 0, 0,  SC,  4,  0, 0, 0, 0, 0, 0};
    vecs[12] = '{0,  0, 1, 0, 0, 0, 0,  SI,  0,  0, 1, 0, 0, 0, 0};
    vecs[13] = '{1, 28, 0, 0, 0, 0, 0,  SC,  0,  0, 0, 0, 0, 0, 0};
    vecs[14] = '{0,  0, 0, 1, 0, 0, 0,  SC, 10,  0, 0, 0, 0, 0, 0};
    vecs[15] = '{0,  0, 0, 1, 0, 0, 0,  SC, 20,  0, 0, 0, 0, 0, 0};
    vecs[16] = '{0,  0, 1, 0, 0, 1, 0,  SS, -1, 20, 0, 0, 0, 1, 0};
    vecs[17] = '{0,  0, 0, 0, 0, 0, 0,  SW, -1,  0, 0, 0, 0, 0, 0};
    vecs[18] = '{0,  0, 0, 0, 0, 0, 1,  SI,  0,  0, 0, 1, 0, 0, 0};
    vecs[19] = '{1, 12, 0, 0, 0, 0, 0,  SC,  0,  0, 0, 0, 0, 0, 0};
    vecs[20] = '{0,  0, 1, 0, 1, 0, 0,  SS, -1,  8, 0, 0, 0, 1, 0};
    vecs[21] = '{0,  0, 0, 0, 0, 0, 0,  SW, -1,  0, 0, 0, 0, 0, 0};
    vecs[22] = '{0,  0, 0, 0, 0, 0, 1,  SI,  0,  0, 1, 0, 0, 0, 0};
    vecs[23] = '{1, 10, 0, 0, 0, 0, 0,  SC,  0,  0, 0, 0, 0, 0, 0};
    vecs[24] = '{0,  0, 0, 0, 0, 1, 0,  SI,  0,  0, 0, 1, 0, 0, 0};
    vecs[25] = '{1, 20, 0, 0, 0, 0, 0,  SC,  0,  0, 0, 0, 0, 0, 0};
    vecs[26] = '{0,  0, 0, 0, 1, 0, 0,  SI,  0,  0, 1, 0, 0, 0, 0};

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_all("reset", SI, 0, 0, 0, 0, 0, 0, 0);

    // Scripted vector table.
    for (int i = 0; i < NumVecs; i++) begin
      drive(vecs[i].pv, vecs[i].pr, vecs[i].c2, vecs[i].n10, vecs[i].n20, vecs[i].cn,
            vecs[i].nml);
      tick();
      idle_inputs();
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].pd, vecs[i].mtg, vecs[i].sd,
                vecs[i].rd, vecs[i].pe, vecs[i].ir, vecs[i].df);
    end

    // Dispenser never answers: fault after exactly TIMEOUT wait cycles.
    drive(1, 4, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    tick();
    idle_inputs();
    check_all("timeout_issue", SS, -1, 6, 0, 0, 0, 0, 0);
    tick();
    check_all("timeout_wait", SW, -1, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (n < TbTimeout + 10) begin
      tick();
      n++;
      if (dispenseFault) break;
    end
    check("timeout_cycles", n, TbTimeout);
    check_all("timeout_end", SI, 0, 0, 0, 0, 0, 0, 1);

    // Reset mid-collection abandons the transaction without any pulse.
    drive(1, 20, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0, 0);
    tick();
    idle_inputs();
    check_all("pre_reset", SC, 12, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    check_all("mid_reset", SI, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check_all("post_reset", SI, 0, 0, 0, 0, 0, 0, 0);

    // Random transactions against the transaction-level model.
    for (int t = 0; t < NumRandom; t++) random_txn(t);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/payment_collector.md
PAYMENT_COLLECTOR -- requirements
Module: payment_collector

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning the maximum cycles spent in WAIT_DISPENSE before a fault.
REQ-002 SHALL have port clock  in  1  as the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  as the reset, synchronous and active-high.
REQ-004 SHALL have port priceValid  in  1  as a one-cycle strobe qualifying price.
REQ-005 SHALL have port price  in  5  as the article price in euros.
REQ-006 SHALL have ports coin2In, note10In, note20In  in  1 each  as one-cycle insertion pulses.
REQ-007 SHALL have port cancel  in  1  as a customer abort request.
REQ-008 SHALL have port noMoneyLeft  in  1  as the dispenser completion pulse.
REQ-009 SHALL have port moneyToGive  out  5  as the change or refund amount for the dispenser.
REQ-010 SHALL have ports saleDone, refundDone, priceError, insertReject, dispenseFault  out  1 each  as registered one-cycle pulses.
REQ-011 SHALL have ports paid  out  6  (running total), busy  out  1, and state  out  3.

Function
REQ-012 SHALL implement states IDLE, COLLECT, ISSUE, WAIT_DISPENSE.
REQ-013 IDLE: on priceValid, price accepted only if even and 2..28; accepted -> COLLECT next cycle, price latched, paid=0; otherwise priceError pulse, stay IDLE.
REQ-014 COLLECT: at most one insertion counted per cycle, priority note20 > note10 > coin2; each other simultaneous pulse -> insertReject pulse.
REQ-015 Counted insertion of d: if paid+d >= price, latch change = paid+d-price and go to ISSUE; otherwise paid += d and stay in COLLECT.
REQ-016 Change equal to 0 SHALL skip ISSUE/WAIT_DISPENSE: saleDone pulse, -> IDLE.
REQ-017 cancel in COLLECT SHALL take priority over a same-cycle insertion (which is rejected); refund = paid; refund 0 -> refundDone pulse, -> IDLE; refund > 0 -> ISSUE.
REQ-018 ISSUE: moneyToGive = latched amount for exactly one cycle, then 0; -> WAIT_DISPENSE.
REQ-019 WAIT_DISPENSE: on noMoneyLeft, saleDone or refundDone pulse (per origin), -> IDLE, paid cleared.
REQ-020 WAIT_DISPENSE timeout: counter reaching TIMEOUT without noMoneyLeft -> dispenseFault pulse, -> IDLE.
REQ-021 Insertions in IDLE, ISSUE or WAIT_DISPENSE SHALL produce insertReject; cancel outside COLLECT is ignored; priceValid outside IDLE is ignored.
REQ-022 Arithmetic SHALL be 6-bit internally (max paid+d = 46); moneyToGive never exceeds 26 and is always even.
REQ-023 busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 reset SHALL force IDLE, clear paid, latched price/change, and timeout counter, and drive moneyToGive=0, all pulses 0, busy=0.
REQ-025 reset mid-transaction SHALL abandon it without refund or pulse.

Structure
REQ-026 State encodings, denominations (2, 10, 20), and max price (28) SHALL reside in a shared package.
REQ-027 Implementation SHALL be a single module; the timeout counter MAY be a sub-module dispense_watchdog.

Verification
REQ-028 price=16, note10, note10 -> ISSUE with moneyToGive=4 for one cycle; noMoneyLeft -> saleDone.
REQ-029 price=6, coin2 x3 -> saleDone without moneyToGive ever nonzero.
REQ-030 price=28, note10 x2, then cancel -> moneyToGive=20; noMoneyLeft -> refundDone.
REQ-031 price=7 and price=30 -> priceError, stay IDLE; coin2+note20 together at price=12 -> change 8, one insertReject.
REQ-032 price=4, note10, no noMoneyLeft -> dispenseFault after TIMEOUT cycles, IDLE.
REQ-033 reset asserted in COLLECT with paid=12 -> next cycle IDLE, paid=0, all outputs 0.
